// File: rtl/backbone2vinput_v2.sv
// Streaming scaler: vinput = backbone * M / D with M, D built from alpha_u table factors.
// Fixed-latency float pipeline feeding a credit-managed first-word-fall-through output FIFO.
module backbone2vinput_v2 #(
  parameter int J         = 14,
  parameter int A         = 2,
  parameter int DW        = 64,
  parameter int MUL_LAT   = 6,
  parameter int DIV_LAT   = 29,
  parameter int OUT_DEPTH = 64,
  parameter int RW        = $clog2(J) + 1,
  parameter int CW        = $clog2(A) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [J*A*DW-1:0] alpha_u,
  input  logic              alpha_u_tvalid,
  output logic              alpha_loaded,
  input  logic [DW-1:0]     backbone_tdata,
  input  logic              backbone_tvalid,
  output logic              backbone_tready,
  input  logic [1:0]        term_mode,
  input  logic [RW-1:0]     term_m_row1,
  input  logic [RW-1:0]     term_m_row2,
  input  logic [RW-1:0]     term_d_row1,
  input  logic [RW-1:0]     term_d_row2,
  input  logic [CW-1:0]     term_m_col1,
  input  logic [CW-1:0]     term_m_col2,
  input  logic [CW-1:0]     term_d_col1,
  input  logic [CW-1:0]     term_d_col2,
  input  logic              term_tlast,
  input  logic              term_tvalid,
  output logic              term_tready,
  output logic [DW-1:0]     vinput_tdata,
  output logic              vinput_tvalid,
  output logic              vinput_tlast,
  input  logic              vinput_tready,
  output logic              err_idx
);
  localparam logic [DW-1:0] ONE  = DW'(64'h3FF0_0000_0000_0000);
  localparam logic [DW-1:0] QNAN = DW'(64'h7FF8_0000_0000_0000);
  localparam logic [DW-1:0] QBIT = DW'(64'h0008_0000_0000_0000);
  localparam int CRW = $clog2(OUT_DEPTH + 1);
  localparam int PW  = $clog2(OUT_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Round-to-nearest-even and pack; denormal results flush to signed zero.
  function automatic logic [DW-1:0] round_pack(input logic s, input int e_in, input logic [52:0] sig,
                                               input logic rnd, input logic stk);
    logic [53:0]   r;
    int            e;
    logic [DW-1:0] res;
    e = e_in;
    r = {1'b0, sig} + {53'd0, (rnd & (stk | sig[0]))};
    if (r[53]) begin
      r = r >> 1;
      e = e + 1;
    end
    if (e >= 2047)   res = {s, 11'h7FF, 52'd0};
    else if (e <= 0) res = {s, 63'd0};
    else             res = {s, e[10:0], r[51:0]};
    return res;
  endfunction

  function automatic logic [DW-1:0] fp_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic          s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [105:0]  p;
    int            e;
    logic [DW-1:0] res;
    s      = a[63] ^ b[63];
    a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    a_zero = (a[62:52] == 11'd0);
    b_zero = (b[62:52] == 11'd0);
    p = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
    e = int'(a[62:52]) + int'(b[62:52]) - 1023;
    if (p[105]) e = e + 1;
    else        p = p << 1;
    if (a_nan)                                     res = a | QBIT;
    else if (b_nan)                                res = b | QBIT;
    else if ((a_inf & b_zero) | (b_inf & a_zero))  res = QNAN;
    else if (a_inf | b_inf)                        res = {s, 11'h7FF, 52'd0};
    else if (a_zero | b_zero)                      res = {s, 63'd0};
    else                                           res = round_pack(s, e, p[105:53], p[52], |p[51:0]);
    return res;
  endfunction

  function automatic logic [DW-1:0] fp_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic          s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [107:0]  num, den;
    logic [55:0]   q;
    logic [52:0]   rm;
    int            e;
    logic [DW-1:0] res;
    s      = a[63] ^ b[63];
    a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    a_zero = (a[62:52] == 11'd0);
    b_zero = (b[62:52] == 11'd0);
    num = {1'b1, a[51:0], 55'd0};
    den = {55'd0, 1'b1, b[51:0]};
    q   = 56'(num / den);
    rm  = 53'(num % den);
    e   = int'(a[62:52]) - int'(b[62:52]) + 1023;
    if (a_nan)                                      res = a | QBIT;
    else if (b_nan)                                 res = b | QBIT;
    else if ((a_inf & b_inf) | (a_zero & b_zero))   res = QNAN;
    else if (a_inf | b_zero)                        res = {s, 11'h7FF, 52'd0};
    else if (a_zero | b_inf)                        res = {s, 63'd0};
    else if (q[55]) res = round_pack(s, e, q[55:3], q[2], q[1] | q[0] | (rm != 53'd0));
    else            res = round_pack(s, e - 1, q[54:2], q[1], q[0] | (rm != 53'd0));
    return res;
  endfunction

  logic [J*A*DW-1:0] alpha_q;
  logic              alpha_loaded_q, err_idx_q;
  logic [DW-1:0]     bb_q;
  state_t            state_q, state_d;
  logic [CRW-1:0]    credits_q, credits_d;

  function automatic logic idx_ok(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return (int'(r) < J) && (int'(c) < A);
  endfunction

  function automatic logic [DW-1:0] alpha_at(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic [DW-1:0] v;
    v = ONE;
    if (idx_ok(r, c)) v = alpha_q[(int'(r) * A + int'(c)) * DW +: DW];
    return v;
  endfunction

  logic bb_hs_s, term_hs_s, out_hs_s, fifo_push_s;
  assign bb_hs_s   = backbone_tvalid & backbone_tready;
  assign term_hs_s = term_tvalid & term_tready;
  assign out_hs_s  = vinput_tvalid & vinput_tready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bb_hs_s) state_d = RUN;
      RUN:     if (term_hs_s && term_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    backbone_tready = 1'b0;
    term_tready     = 1'b0;
    case (state_q)
      IDLE:    backbone_tready = alpha_loaded_q;
      RUN:     term_tready     = (credits_q != CRW'(0));
      default: begin end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alpha_loaded_q <= 1'b0;
    end else if (alpha_u_tvalid && state_q == IDLE) begin
      alpha_q        <= alpha_u;
      alpha_loaded_q <= 1'b1;
    end
    if (bb_hs_s) bb_q <= backbone_tdata;
  end

  // Simultaneous take and return leave the credit count unchanged.
  always_comb begin
    credits_d = credits_q;
    case ({term_hs_s, out_hs_s})
      2'b10:   credits_d = credits_q - CRW'(1);
      2'b01:   credits_d = credits_q + CRW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) credits_q <= CRW'(OUT_DEPTH);
    else     credits_q <= credits_d;
  end

  logic [DW-1:0] m1_s, m2_s, d1_s, d2_s;
  logic          err_s;

  always_comb begin
    m1_s = ONE; m2_s = ONE; d1_s = ONE; d2_s = ONE; err_s = 1'b0;
    case (term_mode)
      2'b01: begin
        m1_s  = alpha_at(term_m_row1, term_m_col1);
        d1_s  = alpha_at(term_d_row1, term_d_col1);
        err_s = !idx_ok(term_m_row1, term_m_col1) || !idx_ok(term_d_row1, term_d_col1);
      end
      2'b10: begin
        m1_s  = alpha_at(term_m_row1, term_m_col1);
        m2_s  = alpha_at(term_m_row2, term_m_col2);
        err_s = !idx_ok(term_m_row1, term_m_col1) || !idx_ok(term_m_row2, term_m_col2);
      end
      2'b11: begin
        m1_s  = alpha_at(term_m_row1, term_m_col1);
        m2_s  = alpha_at(term_m_row2, term_m_col2);
        d1_s  = alpha_at(term_d_row1, term_d_col1);
        d2_s  = alpha_at(term_d_row2, term_d_col2);
        err_s = !idx_ok(term_m_row1, term_m_col1) || !idx_ok(term_m_row2, term_m_col2) ||
                !idx_ok(term_d_row1, term_d_col1) || !idx_ok(term_d_row2, term_d_col2);
      end
      default: begin end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                     err_idx_q <= 1'b0;
    else if (term_hs_s && err_s) err_idx_q <= 1'b1;
  end

  logic          s0_vld_q, s0_last_q;
  logic [DW-1:0] s0_bb_q, s0_m1_q, s0_m2_q, s0_d1_q, s0_d2_q;
  logic          mp_vld_q [MUL_LAT];
  logic          mp_last_q [MUL_LAT];
  logic [DW-1:0] mp_m_q [MUL_LAT];
  logic [DW-1:0] mp_d_q [MUL_LAT];
  logic [DW-1:0] mp_bb_q [MUL_LAT];
  logic          xp_vld_q [MUL_LAT];
  logic          xp_last_q [MUL_LAT];
  logic [DW-1:0] xp_n_q [MUL_LAT];
  logic [DW-1:0] xp_d_q [MUL_LAT];
  logic          dp_vld_q [DIV_LAT];
  logic          dp_last_q [DIV_LAT];
  logic [DW-1:0] dp_q_q [DIV_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld_q <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) begin
        mp_vld_q[i] <= 1'b0;
        xp_vld_q[i] <= 1'b0;
      end
      for (int i = 0; i < DIV_LAT; i++) dp_vld_q[i] <= 1'b0;
    end else begin
      s0_vld_q    <= term_hs_s;
      mp_vld_q[0] <= s0_vld_q;
      xp_vld_q[0] <= mp_vld_q[MUL_LAT-1];
      dp_vld_q[0] <= xp_vld_q[MUL_LAT-1];
      for (int i = 1; i < MUL_LAT; i++) begin
        mp_vld_q[i] <= mp_vld_q[i-1];
        xp_vld_q[i] <= xp_vld_q[i-1];
      end
      for (int i = 1; i < DIV_LAT; i++) dp_vld_q[i] <= dp_vld_q[i-1];
    end
  end

  // Backbone rides along with its term, so a newer backbone never disturbs in-flight work.
  always_ff @(posedge clk) begin
    if (term_hs_s) begin
      s0_m1_q <= m1_s; s0_m2_q <= m2_s; s0_d1_q <= d1_s; s0_d2_q <= d2_s;
      s0_bb_q <= bb_q; s0_last_q <= term_tlast;
    end
    mp_m_q[0]    <= fp_mul(s0_m1_q, s0_m2_q);
    mp_d_q[0]    <= fp_mul(s0_d1_q, s0_d2_q);
    mp_bb_q[0]   <= s0_bb_q;
    mp_last_q[0] <= s0_last_q;
    xp_n_q[0]    <= fp_mul(mp_bb_q[MUL_LAT-1], mp_m_q[MUL_LAT-1]);
    xp_d_q[0]    <= mp_d_q[MUL_LAT-1];
    xp_last_q[0] <= mp_last_q[MUL_LAT-1];
    dp_q_q[0]    <= fp_div(xp_n_q[MUL_LAT-1], xp_d_q[MUL_LAT-1]);
    dp_last_q[0] <= xp_last_q[MUL_LAT-1];
    for (int i = 1; i < MUL_LAT; i++) begin
      mp_m_q[i] <= mp_m_q[i-1]; mp_d_q[i] <= mp_d_q[i-1];
      mp_bb_q[i] <= mp_bb_q[i-1]; mp_last_q[i] <= mp_last_q[i-1];
      xp_n_q[i] <= xp_n_q[i-1]; xp_d_q[i] <= xp_d_q[i-1]; xp_last_q[i] <= xp_last_q[i-1];
    end
    for (int i = 1; i < DIV_LAT; i++) begin
      dp_q_q[i]    <= dp_q_q[i-1];
      dp_last_q[i] <= dp_last_q[i-1];
    end
  end

  logic [DW:0]    fifo_mem_q [OUT_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CRW-1:0] fifo_cnt_q, fifo_cnt_d;

  assign fifo_push_s = dp_vld_q[DIV_LAT-1];

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({fifo_push_s, out_hs_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CRW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CRW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= PW'(0);
      rd_ptr_q   <= PW'(0);
      fifo_cnt_q <= CRW'(0);
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (fifo_push_s) wr_ptr_q <= (wr_ptr_q == PW'(OUT_DEPTH - 1)) ? PW'(0) : wr_ptr_q + PW'(1);
      if (out_hs_s)    rd_ptr_q <= (rd_ptr_q == PW'(OUT_DEPTH - 1)) ? PW'(0) : rd_ptr_q + PW'(1);
    end
    if (fifo_push_s) fifo_mem_q[wr_ptr_q] <= {dp_last_q[DIV_LAT-1], dp_q_q[DIV_LAT-1]};
  end

  assign vinput_tvalid = (fifo_cnt_q != CRW'(0));
  assign vinput_tdata  = vinput_tvalid ? fifo_mem_q[rd_ptr_q][DW-1:0] : {DW{1'b0}};
  assign vinput_tlast  = vinput_tvalid ? fifo_mem_q[rd_ptr_q][DW] : 1'b0;
  assign alpha_loaded  = alpha_loaded_q;
  assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_backbone2vinput_v2.sv
// Scoreboard bench for backbone2vinput_v2: expected results queued at term accept,
// compared in order as the output stream hands them over.
module tb_backbone2vinput_v2;
  localparam int J = 14, A = 2, DW = 64, ML = 6, DL = 29, OD = 64;
  localparam int RW = $clog2(J) + 1, CW = $clog2(A) + 1;
  localparam int L = 1 + 2 * ML + DL;
  localparam logic [63:0] F1  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F05 = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] F2  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F3  = 64'h4008_0000_0000_0000;
  localparam logic [63:0] F4  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] F6  = 64'h4018_0000_0000_0000;
  localparam logic [63:0] F8  = 64'h4020_0000_0000_0000;
  localparam logic [63:0] F24 = 64'h4038_0000_0000_0000;

  logic              clk = 1'b0, rst = 1'b1;
  logic [J*A*DW-1:0] alpha_u = '0;
  logic              alpha_u_tvalid = 1'b0, alpha_loaded;
  logic [DW-1:0]     backbone_tdata = '0;
  logic              backbone_tvalid = 1'b0, backbone_tready;
  logic [1:0]        term_mode = 2'd0;
  logic [RW-1:0]     term_m_row1 = '0, term_m_row2 = '0, term_d_row1 = '0, term_d_row2 = '0;
  logic [CW-1:0]     term_m_col1 = '0, term_m_col2 = '0, term_d_col1 = '0, term_d_col2 = '0;
  logic              term_tlast = 1'b0, term_tvalid = 1'b0, term_tready;
  logic [DW-1:0]     vinput_tdata;
  logic              vinput_tvalid, vinput_tlast, vinput_tready = 1'b1, err_idx;

  backbone2vinput_v2 #(.J(J), .A(A), .DW(DW), .MUL_LAT(ML), .DIV_LAT(DL), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .alpha_u(alpha_u), .alpha_u_tvalid(alpha_u_tvalid), .alpha_loaded(alpha_loaded),
    .backbone_tdata(backbone_tdata), .backbone_tvalid(backbone_tvalid), .backbone_tready(backbone_tready),
    .term_mode(term_mode), .term_m_row1(term_m_row1), .term_m_row2(term_m_row2),
    .term_d_row1(term_d_row1), .term_d_row2(term_d_row2), .term_m_col1(term_m_col1),
    .term_m_col2(term_m_col2), .term_d_col1(term_d_col1), .term_d_col2(term_d_col2),
    .term_tlast(term_tlast), .term_tvalid(term_tvalid), .term_tready(term_tready),
    .vinput_tdata(vinput_tdata), .vinput_tvalid(vinput_tvalid), .vinput_tlast(vinput_tlast),
    .vinput_tready(vinput_tready), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic last; logic [63:0] data; } exp_t;
  exp_t sb_q[$];
  int   total = 0, bad = 0, n_out = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && vinput_tvalid && vinput_tready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {63'd0, vinput_tvalid}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("vdata", vinput_tdata, e.data);
        check("vlast", {63'd0, vinput_tlast}, {63'd0, e.last});
      end
      n_out++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_alpha();
    for (int i = 0; i < J * A; i++) alpha_u[i*DW +: DW] = F1;
    alpha_u[0*DW +: DW] = F2;   // (0,0)
    alpha_u[1*DW +: DW] = F4;   // (0,1)
    alpha_u[2*DW +: DW] = F05;  // (1,0)
    alpha_u_tvalid = 1'b1;
    tick();
    alpha_u_tvalid = 1'b0;
    check("alpha_loaded", {63'd0, alpha_loaded}, 64'd1);
  endtask

  task automatic send_bb(input logic [63:0] v);
    int t = 0;
    backbone_tdata = v; backbone_tvalid = 1'b1;
    @(negedge clk);
    while (!backbone_tready && t < 300) begin @(negedge clk); t++; end
    check("bb_tready", {63'd0, backbone_tready}, 64'd1);
    tick();
    backbone_tvalid = 1'b0;
  endtask

  task automatic send_term(input logic [1:0] mode, input int mr1, input int mc1, input int mr2, input int mc2,
                           input int dr1, input int dc1, input int dr2, input int dc2,
                           input logic last, input logic [63:0] exp);
    int   t = 0;
    exp_t e;
    term_mode = mode;
    term_m_row1 = RW'(mr1); term_m_col1 = CW'(mc1); term_m_row2 = RW'(mr2); term_m_col2 = CW'(mc2);
    term_d_row1 = RW'(dr1); term_d_col1 = CW'(dc1); term_d_row2 = RW'(dr2); term_d_col2 = CW'(dc2);
    term_tlast = last; term_tvalid = 1'b1;
    @(negedge clk);
    while (!term_tready && t < 300) begin @(negedge clk); t++; end
    check("term_tready", {63'd0, term_tready}, 64'd1);
    if (term_tready) begin
      e.last = last; e.data = exp;
      sb_q.push_back(e);
    end
    tick();
    term_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 3000) begin tick(); t++; end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int lat, seen, n0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_alpha_loaded", {63'd0, alpha_loaded}, 64'd0);
    check("rst_err_idx", {63'd0, err_idx}, 64'd0);
    check("rst_bb_tready", {63'd0, backbone_tready}, 64'd0);
    check("rst_term_tready", {63'd0, term_tready}, 64'd0);
    check("rst_vvalid", {63'd0, vinput_tvalid}, 64'd0);
    check("rst_vlast", {63'd0, vinput_tlast}, 64'd0);
    check("rst_vdata", vinput_tdata, 64'd0);
    load_alpha();

    // Mode 00 pass-through and latency from the handshake cycle
    send_bb(F3);
    send_term(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, F3);
    check("bb_tready_after_last", {63'd0, backbone_tready}, 64'd1);
    lat = 1;
    while (!vinput_tvalid && lat < 200) begin tick(); lat++; end
    check("latency", 64'(lat), 64'(L + 1));
    drain();

    // Mode 11
    send_bb(F3);
    send_term(2'b11, 0, 0, 0, 1, 1, 0, 0, 0, 1'b1, F24);
    drain();

    // Modes 01 and 10, two backbones back to back
    send_bb(F3);
    send_term(2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0, F6);
    send_term(2'b10, 0, 0, 0, 1, 0, 0, 0, 0, 1'b1, F24);
    send_bb(F1);
    send_term(2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0, F2);
    send_term(2'b10, 0, 0, 0, 1, 0, 0, 0, 0, 1'b1, F8);
    drain();
    check("err_idx_clean", {63'd0, err_idx}, 64'd0);

    // Backpressure: exactly OD terms accepted while the consumer stalls
    vinput_tready = 1'b0;
    n0 = n_out;
    send_bb(F3);
    for (int i = 0; i < OD; i++) send_term(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, F3);
    term_mode = 2'b00; term_tlast = 1'b0; term_tvalid = 1'b1;
    seen = 0;
    repeat (80) begin @(negedge clk); if (term_tready) seen++; end
    check("bp_stall", 64'(seen), 64'd0);
    check("bp_vvalid", {63'd0, vinput_tvalid}, 64'd1);
    check("bp_hold_data", vinput_tdata, F3);
    check("bp_hold_last", {63'd0, vinput_tlast}, 64'd0);
    check("bp_no_out", 64'(n_out - n0), 64'd0);
    tick();
    term_tvalid = 1'b0;
    vinput_tready = 1'b1;
    for (int i = 0; i < 4; i++) send_term(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, (i == 3), F3);
    drain();
    check("bp_count", 64'(n_out - n0), 64'(OD + 4));

    // Out-of-range row index on m1
    send_bb(F3);
    send_term(2'b01, J, 0, 0, 0, 1, 0, 0, 0, 1'b1, F6);
    check("err_idx_set", {63'd0, err_idx}, 64'd1);
    drain();
    check("err_idx_sticky", {63'd0, err_idx}, 64'd1);

    // Reset with terms in flight
    send_bb(F3);
    for (int i = 0; i < 10; i++) send_term(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, (i == 9), F3);
    rst = 1'b1;
    tick();
    check("rr_vvalid", {63'd0, vinput_tvalid}, 64'd0);
    check("rr_err_idx", {63'd0, err_idx}, 64'd0);
    sb_q.delete();
    rst = 1'b0;
    n0 = n_out;
    repeat (100) tick();
    check("rr_no_stale", 64'(n_out - n0), 64'd0);
    check("rr_alpha_loaded", {63'd0, alpha_loaded}, 64'd0);
    check("rr_bb_tready", {63'd0, backbone_tready}, 64'd0);
    load_alpha();
    send_bb(F1);
    send_term(2'b11, 0, 1, 0, 1, 0, 0, 0, 0, 1'b1, F4);
    drain();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/backbone2vinput_v2.md
Name: backbone2vinput_v2

Overview:
Parametrised successor to the backbone-to-vinput scaler. For each accepted term it computes vinput = backbone × M / D, where M and D are each a product of up to two alpha_u table entries selected by row/column indices. A term stream drives the block directly, so it needs no internal index generator. The block adds a per-term mode, full AXI-stream backpressure through a credit-managed output FIFO, index range checking, and a backbone value that travels with each term. It sits between the index/term generator and the vinput consumer.

Parameters:
J, 14, alpha table rows
A, 2, alpha table columns
DW, 64, operand width (IEEE-754 double for DW=64)
MUL_LAT, 6, latency of the multiply IP instance (cycles)
DIV_LAT, 29, latency of the divide IP instance (cycles)
OUT_DEPTH, 64, output FIFO depth; must be ≥ 2*MUL_LAT+DIV_LAT+2
RW, $clog2(J)+1, row index width (derived)
CW, $clog2(A)+1, column index width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alpha_u  in  J*A*DW  alpha table; entry (r,c) at bit offset (r*A+c)*DW
alpha_u_tvalid  in  1  load strobe for alpha_u
alpha_loaded  out  1  alpha table captured at least once since reset
backbone_tdata  in  DW  backbone value
backbone_tvalid  in  1  backbone valid
backbone_tready  out  1  backbone accept
term_mode  in  2  00 none, 01 single, 10 numerator-only, 11 double
term_m_row1, term_m_row2, term_d_row1, term_d_row2  in  RW each  row indices
term_m_col1, term_m_col2, term_d_col1, term_d_col2  in  CW each  column indices
term_tlast  in  1  last term for the current backbone
term_tvalid  in  1  term valid
term_tready  out  1  term accept
vinput_tdata  out  DW  result
vinput_tvalid  out  1  result valid
vinput_tlast  out  1  term_tlast carried through
vinput_tready  in  1  downstream accept
err_idx  out  1  sticky flag: an index was out of range

Behaviour:
- Reset: FSM in IDLE. alpha_loaded=0, err_idx=0, backbone_tready=0, term_tready=0, vinput_tvalid=0, vinput_tlast=0, vinput_tdata=0. Reset also clears the pipeline valid bits, the FIFO, and credits=OUT_DEPTH. A reset mid-operation discards all in-flight results, and none appear afterwards.
- Alpha load: alpha_u is registered when alpha_u_tvalid=1 and the FSM is in IDLE. alpha_loaded then goes high on the next cycle. alpha_u_tvalid in RUN is ignored.
- FSM IDLE: backbone_tready = alpha_loaded (combinational). On a backbone handshake, the value is captured into backbone_reg and the FSM moves to RUN.
- FSM RUN: backbone_tready=0. term_tready = (credits>0) (combinational). On a term handshake with term_tlast=1, the FSM returns to IDLE. The next backbone can be accepted on the following cycle.
- Credits: decrement on a term handshake and increment on a vinput handshake. If both occur in the same cycle, credits are unchanged. credits never exceeds OUT_DEPTH or goes below 0, so the FIFO can never overflow.
- Operand select, registered as stage S0 on accept:
  - mode 00: M=D=1.0
  - mode 01: M=alpha(m1), D=alpha(d1)
  - mode 10: M=alpha(m1)×alpha(m2), D=1.0
  - mode 11: M=alpha(m1)×alpha(m2), D=alpha(d1)×alpha(d2)
  - Unused factors are forced to 1.0 (0x3FF0000000000000).
- Index range: any index that is used and has row≥J or col≥A substitutes 1.0 for that factor and sets err_idx (sticky until reset).
- Backbone alignment: backbone_reg is sampled into S0 alongside the operands. It travels with the term, so a new backbone accepted while old terms are still in flight never corrupts them.
- Pipeline:
  - S0 (1 cycle).
  - Two parallel multipliers form M and D (MUL_LAT).
  - The main multiplier forms backbone×M (MUL_LAT), while D passes through a MUL_LAT shift-register delay.
  - The divider forms (backbone×M)/D (DIV_LAT).
  - The result is written to the first-word-fall-through FIFO together with tlast.
- Latency: L = 1+2*MUL_LAT+DIV_LAT. With the FIFO empty and vinput_tready=1, vinput_tvalid rises exactly L+1 cycles after the term handshake cycle. Throughput is 1 result/cycle. Output order equals term order.
- Output: vinput_tvalid = FIFO non-empty. vinput_tdata and vinput_tlast stay stable while vinput_tvalid=1 and vinput_tready=0.
- Arithmetic: IEEE results are passed through unchanged (e.g. D=0 gives ±inf, NaN propagates); no flagging.
- Simultaneous events: a FIFO write and read in the same cycle keep the occupancy unchanged. A term with term_tlast accepted in a cycle makes backbone_tready assertable from the next cycle.

Test Plan:
1. Mode 00: load alpha; backbone 3.0 (0x4008000000000000), one term with mode 00 and tlast → vinput=0x4008000000000000, tlast=1, L+1 cycles after accept.
2. Mode 11: alpha(0,0)=2.0, alpha(0,1)=4.0, alpha(1,0)=0.5; m1=(0,0), m2=(0,1), d1=(1,0), d2=(0,0); backbone 3.0 → vinput=24.0 (0x4038000000000000).
3. Modes 01 and 10 with the same table: mode 01, m1=(0,1), d1=(0,0) → 6.0 (0x4018000000000000). Mode 10, m1=(0,0), m2=(0,1) → 24.0. Two backbones back-to-back (3.0 then 1.0) with identical terms → outputs 6.0, 24.0, 2.0, 8.0 in order.
4. Backpressure: hold vinput_tready=0 and offer OUT_DEPTH+4 mode-00 terms → exactly OUT_DEPTH accepted, then term_tready=0. Release vinput_tready → all OUT_DEPTH+4 results emerge in order, none lost or duplicated.
5. Out-of-range: mode 01 with m1 row=J → err_idx=1 stays high; result = backbone/alpha(d1).
6. Reset mid-run: assert rst with 10 terms in flight → vinput_tvalid=0 the cycle after; no stale output after release; alpha_loaded=0 and backbone_tready=0 until alpha is reloaded.
